// File: rtl/nervous_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nervous_pkg
//  Purpose  : Shared types and constants for the nerve-signal generator and
//             the NervousShockDetector that consumes its serial stream.
//  Contents : gen_state_t        generator FSM state encoding
//             NERVOUS_IDLE_LEVEL level driven on the line when no frame runs
//             NERVOUS_LFSR_SEED  seed of the noise LFSR
//             lfsr8_step         one step of the 8-bit Fibonacci LFSR
//  Revision : 1.0  initial release
// ============================================================================
package nervous_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE   = 2'd0,
    GEN_SEND   = 2'd1,
    GEN_FINISH = 2'd2
  } gen_state_t;

  localparam logic       NERVOUS_IDLE_LEVEL = 1'b0;
  localparam logic [7:0] NERVOUS_LFSR_SEED  = 8'hA5;

  // Fibonacci LFSR, taps 8,6,5,4 (bit 7 is tap 8); feedback enters at bit 0.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage : nervous_pkg
`default_nettype wire

// File: rtl/nervous_signal_generator_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : nervous_lfsr8
//  Purpose  : Noise source for the generator. An 8-bit Fibonacci LFSR seeded
//             on reset that steps once per bit period when told to. It flags
//             a spike (bit inversion) whenever bits [7:5] are all zero.
//  Ports    : clock      in  system clock
//             reset      in  asynchronous active-high reset (reseeds)
//             advance    in  step the LFSR on this edge
//             spike_now  out inversion flag for the current LFSR value
//             spike_next out inversion flag for the value after one step
//  Revision : 1.0  initial release
// ============================================================================
module nervous_lfsr8
  import nervous_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic advance,
  output logic spike_now,
  output logic spike_next
);

  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;

  assign w_lfsr_next = lfsr8_step(r_lfsr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_lfsr <= NERVOUS_LFSR_SEED;
    else if (advance) r_lfsr <= w_lfsr_next;
  end

  assign spike_now  = (r_lfsr[7:5]      == 3'b000);
  assign spike_next = (w_lfsr_next[7:5] == 3'b000);

endmodule : nervous_lfsr8
`default_nettype wire

// File: rtl/nervous_signal_generator.sv
`default_nettype none
// ============================================================================
//  Module   : nervous_signal_generator
//  Purpose  : Bit-serial nerve-signal source. Captures a pattern word on an
//             accepted start and shifts it out MSB-first, each bit held for
//             BIT_CYCLES clocks, repeating the pass repeat_cnt extra times.
//  Params   : W           pattern width (2..16)
//             BIT_CYCLES  clocks per bit (>=1)
//  Ports    : clock, reset (async, active-high)
//             start/pattern/length/repeat_cnt  request and its arguments
//             ready      idle, start will be accepted
//             serialout  serial line to the detector inputdata
//             active     frame on the line
//             done       one-cycle pulse after the last bit period
//  Macro    : NERVOUS_GEN_NOISE_EN adds LFSR spike injection (nervous_lfsr8).
//  Revision : 1.0  initial release
// ============================================================================
module nervous_signal_generator
  import nervous_pkg::*;
#(
  parameter int W          = 8,
  parameter int BIT_CYCLES = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [W-1:0]           pattern,
  input  logic [$clog2(W):0]     length,
  input  logic [7:0]             repeat_cnt,
  output logic                   ready,
  output logic                   serialout,
  output logic                   active,
  output logic                   done
);

  localparam int LW = $clog2(W) + 1;
  localparam int PW = $clog2(BIT_CYCLES + 1);
  localparam logic [LW-1:0] c_full_len   = LW'(W);
  localparam logic [PW-1:0] c_period_max = PW'(BIT_CYCLES - 1);

  gen_state_t    r_state, w_state;
  logic [W-1:0]  r_shift, w_shift;
  logic [W-1:0]  r_pattern, w_pattern;
  logic [LW-1:0] r_len, w_len;
  logic [LW-1:0] r_bitcnt, w_bitcnt;
  logic [7:0]    r_passcnt, w_passcnt;
  logic [PW-1:0] r_period, w_period;
  logic          r_serial, w_serial;
  logic          r_active, w_active;
  logic          r_ready, w_ready;
  logic          r_done, w_done;

  logic [LW-1:0] w_len_in;
  logic          w_period_end;
  logic          w_adv;
  logic          w_noise_now;
  logic          w_noise_next;

`ifdef NERVOUS_GEN_NOISE_EN
  nervous_lfsr8 u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .advance    (w_adv),
    .spike_now  (w_noise_now),
    .spike_next (w_noise_next)
  );
`else
  assign w_noise_now  = 1'b0;
  assign w_noise_next = 1'b0;
`endif

  // Out-of-range lengths collapse to a full-width pass.
  assign w_len_in     = ((length == '0) || (length > c_full_len)) ? c_full_len : length;
  assign w_period_end = (r_period == c_period_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= GEN_IDLE;
      r_shift   <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_bitcnt  <= '0;
      r_passcnt <= '0;
      r_period  <= '0;
      r_serial  <= NERVOUS_IDLE_LEVEL;
      r_active  <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_pattern <= w_pattern;
      r_len     <= w_len;
      r_bitcnt  <= w_bitcnt;
      r_passcnt <= w_passcnt;
      r_period  <= w_period;
      r_serial  <= w_serial;
      r_active  <= w_active;
      r_ready   <= w_ready;
      r_done    <= w_done;
    end
  end

  // Outputs are computed one cycle ahead and registered, so the line level
  // for the next cycle is derived from the next shift-register MSB.
  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_pattern = r_pattern;
    w_len     = r_len;
    w_bitcnt  = r_bitcnt;
    w_passcnt = r_passcnt;
    w_period  = r_period;
    w_serial  = NERVOUS_IDLE_LEVEL;
    w_active  = 1'b0;
    w_ready   = 1'b0;
    w_done    = 1'b0;
    w_adv     = 1'b0;

    unique case (r_state)
      GEN_IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_state   = GEN_SEND;
          w_shift   = pattern;
          w_pattern = pattern;
          w_len     = w_len_in;
          w_bitcnt  = '0;
          w_passcnt = repeat_cnt;
          w_period  = '0;
          w_active  = 1'b1;
          w_ready   = 1'b0;
          w_serial  = pattern[W-1] ^ w_noise_now;
        end
      end

      GEN_SEND: begin
        w_active = 1'b1;
        w_serial = r_serial;
        if (!w_period_end) begin
          w_period = r_period + 1'b1;
        end else begin
          w_period = '0;
          w_adv    = 1'b1;
          if ((r_bitcnt + 1'b1) == r_len) begin
            if (r_passcnt != 8'd0) begin
              // Next pass starts with no gap from the latched pattern.
              w_shift   = r_pattern;
              w_bitcnt  = '0;
              w_passcnt = r_passcnt - 8'd1;
              w_serial  = r_pattern[W-1] ^ w_noise_next;
            end else begin
              w_state  = GEN_FINISH;
              w_active = 1'b0;
              w_serial = NERVOUS_IDLE_LEVEL;
              w_done   = 1'b1;
            end
          end else begin
            w_shift  = r_shift << 1;
            w_bitcnt = r_bitcnt + 1'b1;
            w_serial = r_shift[W-2] ^ w_noise_next;
          end
        end
      end

      GEN_FINISH: begin
        w_state = GEN_IDLE;
        w_ready = 1'b1;
      end

      default: begin
        w_state = GEN_IDLE;
        w_ready = 1'b1;
      end
    endcase
  end

  assign ready     = r_ready;
  assign serialout = r_serial;
  assign active    = r_active;
  assign done      = r_done;

endmodule : nervous_signal_generator
`default_nettype wire

// File: tb/tb_nervous_signal_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nervous_signal_generator
//  Purpose  : Self-checking bench for nervous_signal_generator. Each frame's
//             expected per-cycle line levels are pushed into a queue when the
//             start is driven and popped as the DUT shifts them out. When
//             NERVOUS_GEN_NOISE_EN is defined the expected bits include the
//             inversions of an independent LFSR model seeded 8'hA5.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nervous_signal_generator;

  localparam int W  = 8;
  localparam int BC = 10;
`ifdef NERVOUS_GEN_NOISE_EN
  localparam bit c_noise = 1'b1;
`else
  localparam bit c_noise = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] pattern;
  logic [3:0]   length;
  logic [7:0]   repeat_cnt;
  logic         ready;
  logic         serialout;
  logic         active;
  logic         done;

  int   checks;
  int   errors;
  logic exp_q[$];
  logic [7:0] m_lfsr;

  nervous_signal_generator #(.W(W), .BIT_CYCLES(BC)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .length     (length),
    .repeat_cnt (repeat_cnt),
    .ready      (ready),
    .serialout  (serialout),
    .active     (active),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: builds the per-cycle expected line levels of a frame.
  task automatic push_frame(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] rep);
    int  eff;
    logic b;
    eff = ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
    for (int p = 0; p <= int'(rep); p++) begin
      for (int i = 0; i < eff; i++) begin
        b = pat[W-1-i];
        if (c_noise && (m_lfsr[7:5] == 3'b000)) b = ~b;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        for (int c = 0; c < BC; c++) exp_q.push_back(b);
      end
    end
  endtask

  // Entered and left at 1 time unit after a rising edge with ready expected.
  task automatic run_frame(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] rep,
                           input int glitch_at, input int abort_at);
    int   n;
    logic e;
    push_frame(pat, len, rep);
    n = exp_q.size();
    start = 1'b1; pattern = pat; length = len; repeat_cnt = rep;
    @(posedge clock); #1;
    start = 1'b0; pattern = ~pat; length = 4'd1; repeat_cnt = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      if (i == glitch_at) begin start = 1'b1; pattern = 8'h55; end
      else start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (serialout !== e || active !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL send pat=%h cyc=%0d serial=%b exp=%b active=%b ready=%b done=%b",
                 pat, i, serialout, e, active, ready, done);
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || active !== 1'b0 || serialout !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse pat=%h done=%b active=%b serial=%b ready=%b exp 1/0/0/0",
               pat, done, active, serialout, ready);
    end
    @(posedge clock); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || active !== 1'b0 || serialout !== 1'b0) begin
      errors++;
      $display("FAIL ready_return pat=%h ready=%b done=%b active=%b serial=%b exp 1/0/0/0",
               pat, ready, done, active, serialout);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (ready !== 1'b1 || serialout !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s ready=%b serial=%b active=%b done=%b exp 1/0/0/0",
               name, ready, serialout, active, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pattern = '0; length = '0; repeat_cnt = '0;
    m_lfsr = 8'hA5;
    #2;
    check_idle_outputs("reset_no_edge");
    @(posedge clock); #1;
    check_idle_outputs("reset_held");
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check_idle_outputs("idle_after_reset");
    #3 reset = 1'b1;
    #1 check_idle_outputs("reset_mid_idle");
    @(negedge clock); reset = 1'b0;
    m_lfsr = 8'hA5;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    run_frame(8'hAA, 4'd8, 8'd0, -1, -1);
  endtask

  task automatic test_repeat();
    run_frame(8'hF0, 4'd4, 8'd2, -1, -1);
  endtask

  task automatic test_lengths();
    run_frame(8'hC3, 4'd0,  8'd0, -1, -1);
    run_frame(8'h3C, 4'd15, 8'd0, -1, -1);
    run_frame(8'h80, 4'd1,  8'd3, -1, -1);
  endtask

  task automatic test_start_ignored();
    run_frame(8'h96, 4'd8, 8'd0, 20, -1);
  endtask

  task automatic test_back_to_back();
    run_frame(8'h5A, 4'd8, 8'd0, -1, -1);
    run_frame(8'hE1, 4'd6, 8'd1, -1, -1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(8'hAA, 4'd8, 8'd0, -1, 35);
    start = 1'b0;
    #2 reset = 1'b1;
    #1 check_idle_outputs("reset_mid_frame");
    exp_q.delete();
    m_lfsr = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_idle_outputs("reset_hold_no_done");
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check_idle_outputs("after_reset_release");
    run_frame(8'hAA, 4'd8, 8'd0, -1, -1);
  endtask

  task automatic test_noise();
    run_frame(8'h00, 4'd8, 8'd255, -1, -1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_repeat();
    test_lengths();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    test_noise();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nervous_signal_generator
`default_nettype wire
